// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//
// Read-after-write interlock for the decode/issue stage. Each architectural
// register r1..r31 has a small pending-write counter. An instruction is held
// while any source it reads still has an outstanding producer, or while its
// destination counter is already full. Writeback retires pending writes using
// the same register number it presents on the register file write port.
//
// Ports:
//   clk            rising-edge clock
//   resetn         asynchronous active-low reset
//   issue_valid    decode holds an instruction requesting issue
//   issue_ready    instruction may issue this cycle (combinational)
//   issue_rj/_use  source register 1 number / instruction reads it
//   issue_rk/_use  source register 2 number / instruction reads it
//   issue_rd/_we   destination register number / instruction writes it
//   retire_valid   writeback commits a register write this cycle
//   retire_rd      register written by writeback
//   flush          discard all pending state
//   busy_mask      bit i set when register i has a nonzero pending count
//   stall_cnt      saturating count of cycles with issue_valid & ~issue_ready
//   underflow_err  sticky flag: a retire hit a register with no pending write
// -----------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rj,
  input  logic        issue_rj_use,
  input  logic [4:0]  issue_rk,
  input  logic        issue_rk_use,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_we,
  input  logic        retire_valid,
  input  logic [4:0]  retire_rd,
  input  logic        flush,
  output logic [31:0] busy_mask,
  output logic [31:0] stall_cnt,
  output logic        underflow_err
);

  // r0 is hardwired and never gets a counter.
  logic [CNT_W-1:0] cnt_r      [1:31];
  logic [CNT_W-1:0] cnt_next_s [1:31];

  logic [31:0] busy_r;
  logic [31:0] busy_next_s;
  logic [31:0] stall_r;
  logic [31:0] stall_next_s;
  logic        uf_r;
  logic        uf_set_s;

  // Per-register status vectors; bit 0 stays 0 so r0 needs no special case.
  logic [31:0] nz_s;
  logic [31:0] full_s;
  logic        src_hz_s;
  logic        sat_hz_s;
  logic        fire_s;

  logic [31:1] inc_s;
  logic [31:1] dec_s;

  // True when a pending counter holds a nonzero value.
  function automatic logic cnt_nonzero(input logic [CNT_W-1:0] c);
    return (c != {CNT_W{1'b0}});
  endfunction

  // True when a pending counter cannot accept another outstanding write.
  function automatic logic cnt_full(input logic [CNT_W-1:0] c);
    return (&c);
  endfunction

  // Decode registered counters into nonzero / full flags per register.
  always_comb begin
    nz_s   = 32'd0;
    full_s = 32'd0;
    for (int i = 1; i < 32; i++) begin
      nz_s[i]   = cnt_nonzero(cnt_r[i]);
      full_s[i] = cnt_full(cnt_r[i]);
    end
  end

  // Hazard detection and issue handshake; uses only registered state, so a
  // retire in this cycle cannot release a dependent source until next cycle.
  always_comb begin
    src_hz_s    = (issue_rj_use & nz_s[issue_rj]) | (issue_rk_use & nz_s[issue_rk]);
    sat_hz_s    = issue_rd_we & full_s[issue_rd];
    issue_ready = ~flush & ~src_hz_s & ~sat_hz_s;
    fire_s      = issue_valid & issue_ready;
  end

  // Next counter values: flush clears, a matched increment/decrement pair
  // cancels (even at zero), and a lone decrement at zero flags underflow.
  always_comb begin
    uf_set_s = 1'b0;
    inc_s    = 31'd0;
    dec_s    = 31'd0;
    for (int i = 1; i < 32; i++) begin
      cnt_next_s[i] = cnt_r[i];
      inc_s[i] = fire_s & issue_rd_we & (issue_rd == 5'(i));
      dec_s[i] = retire_valid & ~flush & (retire_rd == 5'(i));
      if (flush) begin
        cnt_next_s[i] = {CNT_W{1'b0}};
      end else if (inc_s[i] && !dec_s[i]) begin
        // Cannot wrap: a full counter blocks the fire via sat_hz_s.
        cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
      end else if (dec_s[i] && !inc_s[i]) begin
        if (nz_s[i]) begin
          cnt_next_s[i] = cnt_r[i] - CNT_W'(1);
        end else begin
          uf_set_s = 1'b1;
        end
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
    end
  end

  // Busy mask is registered from next-state counters so it tracks cnt_r exactly.
  always_comb begin
    busy_next_s = 32'd0;
    for (int i = 1; i < 32; i++) begin
      busy_next_s[i] = cnt_nonzero(cnt_next_s[i]);
    end
  end

  // Saturating stall counter; flush cycles with a waiting instruction count.
  always_comb begin
    if (issue_valid && !issue_ready && (stall_r != 32'hFFFF_FFFF)) begin
      stall_next_s = stall_r + 32'd1;
    end else begin
      stall_next_s = stall_r;
    end
  end

  // Pending counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i < 32; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end

  // Status outputs: busy mask, stall counter and sticky underflow flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_r  <= 32'd0;
      stall_r <= 32'd0;
      uf_r    <= 1'b0;
    end else begin
      busy_r  <= busy_next_s;
      stall_r <= stall_next_s;
      uf_r    <= uf_r | uf_set_s;
    end
  end

  assign busy_mask     = busy_r;
  assign stall_cnt     = stall_r;
  assign underflow_err = uf_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Directed steps followed by a randomized phase, all compared against a
// behavioural model holding integer pending counts per register.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk;
  logic        resetn;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rj;
  logic        issue_rj_use;
  logic [4:0]  issue_rk;
  logic        issue_rk_use;
  logic [4:0]  issue_rd;
  logic        issue_rd_we;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic        flush;
  logic [31:0] busy_mask;
  logic [31:0] stall_cnt;
  logic        underflow_err;

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rj      (issue_rj),
    .issue_rj_use  (issue_rj_use),
    .issue_rk      (issue_rk),
    .issue_rk_use  (issue_rk_use),
    .issue_rd      (issue_rd),
    .issue_rd_we   (issue_rd_we),
    .retire_valid  (retire_valid),
    .retire_rd     (retire_rd),
    .flush         (flush),
    .busy_mask     (busy_mask),
    .stall_cnt     (stall_cnt),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_cnt [32];
  longint      m_stall;
  bit          m_uf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_stall = 0;
    m_uf    = 1'b0;
  endtask

  function automatic bit model_ready();
    bit hz;
    hz = 1'b0;
    if (flush) hz = 1'b1;
    if (issue_rj_use && issue_rj != 5'd0 && m_cnt[issue_rj] != 0) hz = 1'b1;
    if (issue_rk_use && issue_rk != 5'd0 && m_cnt[issue_rk] != 0) hz = 1'b1;
    if (issue_rd_we && issue_rd != 5'd0 && m_cnt[issue_rd] == MAXC) hz = 1'b1;
    return !hz;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = 32'd0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic drive(input bit v, input int rj, input bit ju, input int rk, input bit ku,
                       input int rd, input bit we, input bit rv, input int rr, input bit fl);
    issue_valid  = v;
    issue_rj     = 5'(rj);
    issue_rj_use = ju;
    issue_rk     = 5'(rk);
    issue_rk_use = ku;
    issue_rd     = 5'(rd);
    issue_rd_we  = we;
    retire_valid = rv;
    retire_rd    = 5'(rr);
    flush        = fl;
  endtask

  // One clock: check issue_ready, advance the model at the edge, check state.
  task automatic cyc(input string tag);
    bit exp_rdy;
    int inc_reg;
    int dec_reg;
    #1;
    exp_rdy = model_ready();
    chk({tag, "_ready"}, {31'd0, issue_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (issue_valid && !exp_rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      inc_reg = (issue_valid && exp_rdy && issue_rd_we && issue_rd != 5'd0) ? int'(issue_rd) : -1;
      dec_reg = (retire_valid && retire_rd != 5'd0) ? int'(retire_rd) : -1;
      if (inc_reg != dec_reg) begin
        if (inc_reg > 0) m_cnt[inc_reg]++;
        if (dec_reg > 0) begin
          if (m_cnt[dec_reg] == 0) m_uf = 1'b1;
          else m_cnt[dec_reg]--;
        end
      end
    end
    #1;
    chk({tag, "_busy"}, busy_mask, model_busy());
    chk({tag, "_stall"}, stall_cnt, m_stall[31:0]);
    chk({tag, "_uf"}, {31'd0, underflow_err}, {31'd0, m_uf});
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_uf", {31'd0, underflow_err}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Reset/idle: first issue is ready, r5 busy afterwards.
    drive(1, 3, 1, 4, 1, 5, 1, 0, 0, 0);
    cyc("idle");
    chk("idle_mask", busy_mask, 32'h0000_0020);

    // RAW stall on r5, retire releases it one cycle later.
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("raw_a");
    cyc("raw_b");
    drive(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    #1 chk("raw_retire_cycle", {31'd0, issue_ready}, 32'd0);
    cyc("raw_c");
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("raw_after", {31'd0, issue_ready}, 32'd1);
    cyc("raw_d");
    chk("raw_stalls", stall_cnt, 32'd3);

    // r0 never busy, retire of r0 never underflows.
    drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
    cyc("r0_a");
    cyc("r0_b");
    chk("r0_uf", {31'd0, underflow_err}, 32'd0);

    // Saturation of r7.
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    cyc("sat_1");
    cyc("sat_2");
    cyc("sat_3");
    #1 chk("sat_full", {31'd0, issue_ready}, 32'd0);
    drive(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    cyc("sat_4");
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    #1 chk("sat_release", {31'd0, issue_ready}, 32'd1);
    cyc("sat_5");

    // Simultaneous issue and retire of r9 leaves its count at 1.
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    cyc("sim_a");
    drive(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
    cyc("sim_b");
    chk("sim_busy9", {31'd0, busy_mask[9]}, 32'd1);

    // Flush clears everything; then retire r2 underflows, sticky.
    drive(1, 1, 1, 0, 0, 2, 1, 1, 7, 1);
    #1 chk("flush_ready", {31'd0, issue_ready}, 32'd0);
    cyc("flush");
    chk("flush_mask", busy_mask, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    cyc("uf_a");
    chk("uf_set", {31'd0, underflow_err}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("uf_b");
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 1);
    cyc("uf_flush");

    // Asynchronous reset mid-cycle.
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    cyc("pre_rst");
    #3 resetn = 1'b0;
    #1;
    chk("arst_busy", busy_mask, 32'd0);
    chk("arst_stall", stall_cnt, 32'd0);
    chk("arst_uf", {31'd0, underflow_err}, 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7),
            $urandom_range(0, 49) == 0);
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Read-after-write interlock that sits in the decode/issue stage, directly upstream of the general register file. It tracks in-flight writes per architectural register using small pending counters. Issue of an instruction is held while any source it reads still has an outstanding producer. Writeback retires entries with the same register number it presents on the register file write port.

## Interface
- CNT_W, 2, width of each per-register pending counter; at most 2^CNT_W−1 outstanding writes per register
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode holds an instruction requesting issue
- issue_ready  out  1  instruction may issue this cycle
- issue_rj  in  5  source register 1 number
- issue_rj_use  in  1  instruction reads rj
- issue_rk  in  5  source register 2 number
- issue_rk_use  in  1  instruction reads rk
- issue_rd  in  5  destination register number
- issue_rd_we  in  1  instruction writes rd
- retire_valid  in  1  writeback commits a register write this cycle (same cycle as register file we)
- retire_rd  in  5  register written by writeback (same value as register file waddr)
- flush  in  1  pipeline flush; discard all pending state
- busy_mask  out  32  bit i set when register i has a nonzero pending count
- stall_cnt  out  32  saturating count of cycles with issue_valid=1 and issue_ready=0
- underflow_err  out  1  sticky; set by a retire to a register whose count is 0

## Operation
- State: 31 counters cnt[1..31], each CNT_W bits. r0 has no counter and is never busy. Also holds stall_cnt and underflow_err.
- Hazard check:
  - src_hz = (issue_rj_use & rj≠0 & cnt[rj]≠0) | (issue_rk_use & rk≠0 & cnt[rk]≠0).
  - sat_hz = issue_rd_we & rd≠0 & cnt[rd] = all-ones.
  - issue_ready = ~flush & ~src_hz & ~sat_hz.
- issue_ready depends only on registered counters and current inputs. It has no dependence on issue_valid or retire_*.
- There is no same-cycle bypass. A source whose only pending write retires this cycle still stalls this cycle. The register file captures the data at this edge, so it is readable next cycle.
- Issue fire: fire = issue_valid & issue_ready. On fire with issue_rd_we & rd≠0, cnt[rd] is incremented.
- Retire: retire_valid & retire_rd≠0 & ~flush decrements cnt[retire_rd].
  - If that count is already 0: the count stays 0 and underflow_err is set.
- Simultaneous fire-increment and retire-decrement on the same register leave the count unchanged. This holds even if the count is 0, and no underflow is flagged in that case.
- Flush: all counters are cleared to 0 at the edge. Issue and retire in the flush cycle are ignored (issue_ready=0 forces no fire). stall_cnt and underflow_err are unaffected.
- stall_cnt increments when issue_valid & ~issue_ready, and saturates at 0xFFFFFFFF. Flush cycles with issue_valid=1 count as stalls.
- busy_mask[0] is constant 0. busy_mask[i] = (cnt[i]≠0) for i = 1..31.

## Timing
- Reset (resetn=0, asynchronous): all cnt=0, busy_mask=0, stall_cnt=0, underflow_err=0.
- First cycle after reset release: issue_ready=1 for any input pattern except flush=1 (rd saturation and source hazards are impossible with all counts 0).
- Assertion of resetn=0 mid-operation clears all state immediately, without waiting for a clock edge.
- Issue-to-busy latency is 1 cycle: busy_mask reflects a fired write at the next edge.
- Retire-to-ready latency is 1 cycle: a dependent source is ready the cycle after its last retire.
- Back-to-back independent issues sustain one fire per cycle.

## Test plan
- Reset/idle: release resetn; issue rj=3, rk=4, rd=5 with uses=1 -> issue_ready=1. Next cycle busy_mask=0x0000_0020.
- RAW stall: issue rd=5. Next cycle present rj=5 -> issue_ready=0. Retire rd=5 in cycle N -> ready still 0 in N, ready=1 in N+1. stall_cnt equals the stalled cycles.
- r0 handling: issue rd=0 with we=1, then rj=0 -> never stalls, busy_mask stays 0. Retire rd=0 -> no underflow.
- Saturation (CNT_W=2): three fires writing r7 with no retire -> cnt=3. Fourth write to r7 -> issue_ready=0. One retire of r7 -> ready=1 next cycle.
- Simultaneous issue+retire: cnt[9]=1; fire write r9 and retire r9 in the same cycle -> cnt[9] stays 1, busy_mask[9]=1.
- Flush/underflow: two regs pending, assert flush -> issue_ready=0 that cycle, busy_mask=0 next cycle. Retire r2 with cnt=0 -> underflow_err=1 and stays 1 until resetn=0.
